// File: rtl/dmem_responder.sv
// dmem_responder: single-port data memory with a fixed-latency
// request/response handshake for RISC-V style loads and stores.
//
// A request is accepted in IDLE when rd or wr is high. The module then waits
// WAIT_STATES cycles and answers in a single RESP cycle. During RESP it pulses
// exactly one of rd_valid, wr_done or err.
//
// Ports
//   clk      : single clock; all state changes happen on its rising edge
//   reset    : asynchronous, active-high
//   wr / rd  : store / load request strobes (both high -> error request)
//   addr     : byte address (9 bits)
//   funct3   : access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   wr_data  : store data, right-aligned
//   busy     : request in flight (WAIT or RESP); new requests are ignored
//   rd_data  : load result; holds until the next load or error response
//   rd_valid : one-cycle pulse, rd_data carries load data
//   wr_done  : one-cycle pulse, store committed
//   err      : one-cycle pulse, request rejected (rd_data forced to 0)
module dmem_responder #(
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned DEPTH_WORDS = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr,
  input  logic        rd,
  input  logic [8:0]  addr,
  input  logic [2:0]  funct3,
  input  logic [31:0] wr_data,
  output logic        busy,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        wr_done,
  output logic        err
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  logic [2:0]  cnt;

  // Request captured at acceptance
  logic [8:0]  a_addr;
  logic [2:0]  a_f3;
  logic [31:0] a_wdata;
  logic        a_wr;
  logic        a_both;

  logic [31:0] rd_q;
  logic [31:0] mem [DEPTH_WORDS];

  logic [AW-1:0] widx;
  logic          bad;
  logic [31:0]   word;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   load_val;
  logic [31:0]   resp_data;
  logic [3:0]    be;
  logic [31:0]   wlane;

  assign widx = a_addr[AW+1:2];
  assign word = mem[widx];

  // Error classification is done on the captured request so that it is
  // stable for the whole in-flight period.
  always_comb begin
    bad = a_both;
    if (a_f3 == 3'b011 || a_f3 == 3'b110 || a_f3 == 3'b111)
      bad = 1'b1;
    if (a_f3[1:0] == 2'b01 && a_addr[0])
      bad = 1'b1;
    if (a_f3[1:0] == 2'b10 && a_addr[1:0] != 2'b00)
      bad = 1'b1;
    if (32'(a_addr[8:2]) >= DEPTH_WORDS)
      bad = 1'b1;
  end

  always_comb begin
    byte_sel = word[{a_addr[1:0], 3'b000} +: 8];
    half_sel = word[{a_addr[1], 4'b0000} +: 16];
    load_val = '0;
    case (a_f3)
      3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
      3'b010:  load_val = word;
      3'b100:  load_val = {24'd0, byte_sel};
      3'b101:  load_val = {16'd0, half_sel};
      default: load_val = '0;
    endcase
    resp_data = bad ? '0 : load_val;
  end

  always_comb begin
    be    = 4'b0000;
    wlane = a_wdata;
    case (a_f3[1:0])
      2'b00: begin
        be    = 4'b0001 << a_addr[1:0];
        wlane = {4{a_wdata[7:0]}};
      end
      2'b01: begin
        be    = a_addr[1] ? 4'b1100 : 4'b0011;
        wlane = {2{a_wdata[15:0]}};
      end
      2'b10: begin
        be    = 4'b1111;
        wlane = a_wdata;
      end
      default: begin
        be    = 4'b0000;
        wlane = a_wdata;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      rd_q    <= '0;
      a_addr  <= '0;
      a_f3    <= '0;
      a_wdata <= '0;
      a_wr    <= 1'b0;
      a_both  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rd || wr) begin
            a_addr  <= addr;
            a_f3    <= funct3;
            a_wdata <= wr_data;
            a_wr    <= wr && !rd;
            a_both  <= wr && rd;
            if (WAIT_STATES == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= 3'(WAIT_STATES);
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1)
            state <= RESP;
        end
        RESP: begin
          state <= IDLE;
          if (bad || !a_wr)
            rd_q <= resp_data;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // No reset on the array: contents survive reset. An abort cannot write
  // because reset forces state out of RESP before the next edge.
  always_ff @(posedge clk) begin
    if (state == RESP && a_wr && !bad) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b])
          mem[widx][8*b +: 8] <= wlane[8*b +: 8];
      end
    end
  end

  // Response outputs are decoded from RESP so reset clears them at once;
  // rd_data shows the fresh result during RESP and the held value otherwise.
  assign busy     = (state != IDLE);
  assign rd_valid = (state == RESP) && !bad && !a_wr;
  assign wr_done  = (state == RESP) && !bad && a_wr;
  assign err      = (state == RESP) && bad;
  assign rd_data  = ((state == RESP) && (bad || !a_wr)) ? resp_data : rd_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam logic [2:0] K_RD = 3'b001;
  localparam logic [2:0] K_WR = 3'b010;
  localparam logic [2:0] K_ER = 3'b100;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  typedef struct {
    logic [2:0]  kind;
    logic [31:0] data;
    string       tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  // Index 0: WAIT_STATES=1, index 1: WAIT_STATES=3, index 2: WAIT_STATES=0
  logic [2:0]        rd = '0;
  logic [2:0]        wr = '0;
  logic [2:0][2:0]   f3_i = '0;
  logic [2:0][8:0]   addr_i = '0;
  logic [2:0][31:0]  wd_i = '0;
  logic [2:0]        busy;
  logic [2:0]        rd_valid;
  logic [2:0]        wr_done;
  logic [2:0]        err;
  logic [2:0][31:0]  rd_data;

  exp_t        sb[$];
  logic [31:0] last_rd [3];
  int          n_vec = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  dmem_responder #(.WAIT_STATES(1), .DEPTH_WORDS(128)) u_dut1 (
    .clk(clk), .reset(rst), .wr(wr[0]), .rd(rd[0]), .addr(addr_i[0]),
    .funct3(f3_i[0]), .wr_data(wd_i[0]), .busy(busy[0]), .rd_data(rd_data[0]),
    .rd_valid(rd_valid[0]), .wr_done(wr_done[0]), .err(err[0])
  );

  dmem_responder #(.WAIT_STATES(3), .DEPTH_WORDS(128)) u_dut3 (
    .clk(clk), .reset(rst), .wr(wr[1]), .rd(rd[1]), .addr(addr_i[1]),
    .funct3(f3_i[1]), .wr_data(wd_i[1]), .busy(busy[1]), .rd_data(rd_data[1]),
    .rd_valid(rd_valid[1]), .wr_done(wr_done[1]), .err(err[1])
  );

  dmem_responder #(.WAIT_STATES(0), .DEPTH_WORDS(128)) u_dut0 (
    .clk(clk), .reset(rst), .wr(wr[2]), .rd(rd[2]), .addr(addr_i[2]),
    .funct3(f3_i[2]), .wr_data(wd_i[2]), .busy(busy[2]), .rd_data(rd_data[2]),
    .rd_valid(rd_valid[2]), .wr_done(wr_done[2]), .err(err[2])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] pulses(input int d);
    return {err[d], wr_done[d], rd_valid[d]};
  endfunction

  // One request on instance d; the expected response goes on the scoreboard
  // when the request is driven and is popped when a response pulse appears.
  task automatic do_req(input int d, input int ws, input logic r, input logic w,
                        input logic [2:0] f3, input logic [8:0] a,
                        input logic [31:0] wd, input logic [2:0] kind,
                        input logic [31:0] exp_data, input string tag);
    exp_t       e;
    int         lat;
    logic [2:0] p;
    e.kind = kind;
    e.data = exp_data;
    e.tag  = tag;
    sb.push_back(e);
    @(negedge clk);
    chk({tag, "/idle"}, 32'(busy[d]), 32'd0);
    rd[d] = r; wr[d] = w; f3_i[d] = f3; addr_i[d] = a; wd_i[d] = wd;
    @(negedge clk);
    // Scramble inputs: the in-flight request must not see these
    rd[d] = 1'b0; wr[d] = 1'b0; addr_i[d] = ~a; wd_i[d] = ~wd; f3_i[d] = f3 ^ 3'b001;
    lat = 1;
    p = pulses(d);
    while (p == 3'b000 && lat < 16) begin
      @(negedge clk);
      lat++;
      p = pulses(d);
    end
    chk({tag, "/latency"}, 32'(lat), 32'(ws + 1));
    if (sb.size() == 0) begin
      chk({tag, "/scoreboard_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({e.tag, "/kind"}, 32'(p), 32'(e.kind));
      chk({e.tag, "/busy_resp"}, 32'(busy[d]), 32'd1);
      if (e.kind == K_WR) begin
        chk({e.tag, "/rd_data_hold"}, rd_data[d], last_rd[d]);
      end else begin
        chk({e.tag, "/rd_data"}, rd_data[d], e.data);
        last_rd[d] = e.data;
      end
    end
    @(negedge clk);
    chk({tag, "/pulse_end"}, 32'(pulses(d)), 32'd0);
    chk({tag, "/busy_end"}, 32'(busy[d]), 32'd0);
  endtask

  initial begin
    logic [2:0] acc;
    for (int i = 0; i < 3; i++) last_rd[i] = '0;

    // Reset state, asserted off the clock edge
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("reset/busy", 32'(busy[i]), 32'd0);
      chk("reset/pulses", 32'(pulses(i)), 32'd0);
      chk("reset/rd_data", rd_data[i], 32'd0);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // WAIT_STATES = 1
    do_req(0, 1, 1'b0, 1'b1, F_W,  9'd8,  32'hDEADBEEF, K_WR, 32'h0,        "sw8");
    do_req(0, 1, 1'b1, 1'b0, F_W,  9'd8,  32'h0,        K_RD, 32'hDEADBEEF, "lw8");
    do_req(0, 1, 1'b1, 1'b0, F_B,  9'd9,  32'h0,        K_RD, 32'hFFFFFFBE, "lb9");
    do_req(0, 1, 1'b1, 1'b0, F_BU, 9'd9,  32'h0,        K_RD, 32'h000000BE, "lbu9");
    do_req(0, 1, 1'b1, 1'b0, F_H,  9'd10, 32'h0,        K_RD, 32'hFFFFDEAD, "lh10");
    do_req(0, 1, 1'b1, 1'b0, F_HU, 9'd10, 32'h0,        K_RD, 32'h0000DEAD, "lhu10");
    do_req(0, 1, 1'b0, 1'b1, F_B,  9'd8,  32'hFFFFFF12, K_WR, 32'h0,        "sb8");
    do_req(0, 1, 1'b1, 1'b0, F_W,  9'd8,  32'h0,        K_RD, 32'hDEADBE12, "lw8_after_sb");
    do_req(0, 1, 1'b1, 1'b0, F_W,  9'd6,  32'h0,        K_ER, 32'h0,        "lw6_misaligned");
    do_req(0, 1, 1'b0, 1'b1, F_H,  9'd9,  32'h00007777, K_ER, 32'h0,        "sh9_misaligned");
    do_req(0, 1, 1'b1, 1'b0, F_W,  9'd8,  32'h0,        K_RD, 32'hDEADBE12, "lw8_after_bad_sh");
    do_req(0, 1, 1'b1, 1'b1, F_W,  9'd8,  32'h0,        K_ER, 32'h0,        "rd_wr_both");
    do_req(0, 1, 1'b1, 1'b0, F_W,  9'd8,  32'h0,        K_RD, 32'hDEADBE12, "lw8_after_both");
    do_req(0, 1, 1'b1, 1'b0, 3'b011, 9'd8, 32'h0,       K_ER, 32'h0,        "f3_011");
    do_req(0, 1, 1'b0, 1'b1, 3'b111, 9'd8, 32'h0,       K_ER, 32'h0,        "f3_111_store");
    do_req(0, 1, 1'b0, 1'b1, F_H,  9'd10, 32'hABCD1234, K_WR, 32'h0,        "sh10");
    do_req(0, 1, 1'b1, 1'b0, F_W,  9'd8,  32'h0,        K_RD, 32'h1234BE12, "lw8_after_sh");
    do_req(0, 1, 1'b1, 1'b0, F_B,  9'd10, 32'h0,        K_RD, 32'h00000034, "lb10");
    do_req(0, 1, 1'b1, 1'b0, F_B,  9'd11, 32'h0,        K_RD, 32'h00000012, "lb11");

    // WAIT_STATES = 3, reset abort in WAIT
    do_req(1, 3, 1'b0, 1'b1, F_W, 9'd0, 32'h11223344, K_WR, 32'h0, "w3_sw0");
    @(negedge clk);
    rd[1] = 1'b0; wr[1] = 1'b1; f3_i[1] = F_W; addr_i[1] = 9'd0; wd_i[1] = 32'h00000055;
    @(negedge clk);
    wr[1] = 1'b0;
    chk("abort/busy_wait", 32'(busy[1]), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort/busy_now", 32'(busy[1]), 32'd0);
    chk("abort/pulses_now", 32'(pulses(1)), 32'd0);
    chk("abort/rd_data_now", rd_data[1], 32'd0);
    for (int i = 0; i < 3; i++) last_rd[i] = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    acc = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      acc = acc | pulses(1);
    end
    chk("abort/no_response", 32'(acc), 32'd0);
    do_req(1, 3, 1'b1, 1'b0, F_W, 9'd0, 32'h0, K_RD, 32'h11223344, "w3_lw0_prior");

    // WAIT_STATES = 0
    do_req(2, 0, 1'b0, 1'b1, F_W, 9'd0, 32'hCAFEF00D, K_WR, 32'h0,        "w0_sw0");
    do_req(2, 0, 1'b1, 1'b0, F_W, 9'd0, 32'h0,        K_RD, 32'hCAFEF00D, "w0_lw0");

    // Load held high: re-accepted on every IDLE cycle, one response each
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      e.kind = K_RD;
      e.data = 32'hCAFEF00D;
      e.tag  = "held";
      sb.push_back(e);
    end
    @(negedge clk);
    rd[2] = 1'b1; f3_i[2] = F_W; addr_i[2] = 9'd0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("held/busy", 32'(busy[2]), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("held/rd_valid", 32'(rd_valid[2]), (i % 2 == 0) ? 32'd1 : 32'd0);
      if (rd_valid[2]) begin
        if (sb.size() == 0) begin
          chk("held/extra_response", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk({e.tag, "/rd_data"}, rd_data[2], e.data);
        end
      end
      if (i == 7) rd[2] = 1'b0;
    end
    chk("held/responses_left", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
